hdmi_packet_scheduler: RTL and testbench

//  Picks which data-island packet occupies each 32-pixel packet slot. It arbitrates ACR,

---
 rtl/hdmi_packet_pkg.sv | 20 ++
 rtl/hdmi_packet_scheduler_rr_arbiter.sv | 32 +++
 rtl/hdmi_packet_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type codes, slot geometry and FSM state for the HDMI packet scheduler.
// Used by hdmi_packet_scheduler and its round-robin arbiter.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL     = 8'h00;
    localparam logic [7:0] PKT_ACR      = 8'h01;
    localparam logic [7:0] PKT_AUDIO    = 8'h02;
    localparam logic [7:0] PKT_AVI      = 8'h82;
    localparam logic [7:0] PKT_SPD      = 8'h83;
    localparam logic [7:0] PKT_AUDIO_IF = 8'h84;

    localparam int SLOT_LEN = 32;
    localparam int CNT_W    = $clog2(SLOT_LEN);

    typedef enum logic {
        ST_IDLE,
        ST_SLOT
    } state_e;

endpackage

// File: rtl/hdmi_packet_scheduler_rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr_i and wraps.
// Returns a one-hot grant and a valid flag; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pend_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [N-1:0]   rot;
    logic [N-1:0]   grot;
    logic [2*N-1:0] gnt2;

    always_comb begin
        // rotate so bit 0 is the first candidate, pick lowest, rotate back
        rot     = N'({pend_i, pend_i} >> ptr_i);
        grot    = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !valid_o) begin
                grot[k] = 1'b1;
                valid_o = 1'b1;
            end
        end
        gnt2  = {{N{1'b0}}, grot} << ptr_i;
        gnt_o = gnt2[N-1:0] | gnt2[2*N-1:N];
    end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Data-island slot scheduler: ACR > audio > round-robin InfoFrames > NULL.
// Optional PACKET_SCHED_STATS_EN adds saturating miss/null/forced counters.
module hdmi_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int                  NUM_IF        = 3,
    parameter logic [8*NUM_IF-1:0] IF_TYPE       = {PKT_SPD, PKT_AVI, PKT_AUDIO_IF},
    parameter int                  IF_FIELDS     = 1,
    parameter int                  MAX_AUDIO_RUN = 4
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              video_field_end,
    input  logic              packet_enable,
    input  logic              req_acr,
    input  logic              req_audio,
    input  logic [NUM_IF-1:0] if_enable,
    output logic [7:0]        packet_type,
    output logic              grant_acr,
    output logic              grant_audio,
    output logic [NUM_IF-1:0] grant_if,
    output logic              slot_busy,
    output logic              if_missed
`ifdef PACKET_SCHED_STATS_EN
   ,output logic [15:0]       stat_missed,
    output logic [15:0]       stat_null,
    output logic [15:0]       stat_forced
`endif
);

    localparam int PW = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
    localparam int RW = $clog2(MAX_AUDIO_RUN + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        ptype_q, ptype_d;
    logic              gacr_q, gacr_d;
    logic              gaud_q, gaud_d;
    logic [NUM_IF-1:0] gif_q, gif_d;
    logic [NUM_IF-1:0] sent_q, sent_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [RW-1:0]     run_q, run_d;
    logic              field_q, field_d;
    logic              miss_q, miss_d;

    logic              accept, period_end, force_if, arb_valid;
    logic [NUM_IF-1:0] sent_eff, pend, arb_gnt;
    logic [PW-1:0]     gnt_idx;
    logic [7:0]        gnt_type;

    // period end clears sent flags before the same-cycle decision sees them
    assign period_end = video_field_end && (IF_FIELDS == 1 || field_q);
    assign sent_eff   = period_end ? '0 : sent_q;
    assign pend       = if_enable & ~sent_eff;
    assign accept     = packet_enable &&
                        (state_q == ST_IDLE || cnt_q == CNT_W'(SLOT_LEN - 1));
    assign force_if   = (run_q == RW'(MAX_AUDIO_RUN)) && arb_valid;

    rr_arbiter #(.N(NUM_IF), .PW(PW)) u_arb (
        .pend_i  (pend),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    always_comb begin
        gnt_idx  = '0;
        gnt_type = PKT_NULL;
        for (int k = 0; k < NUM_IF; k++) begin
            if (arb_gnt[k]) begin
                gnt_idx  = PW'(k);
                gnt_type = IF_TYPE[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptype_d = ptype_q;
        gacr_d  = 1'b0;
        gaud_d  = 1'b0;
        gif_d   = '0;
        sent_d  = sent_eff;
        ptr_d   = ptr_q;
        run_d   = run_q;
        field_d = period_end ? 1'b0 : (field_q ^ video_field_end);
        miss_d  = period_end && |(if_enable & ~sent_q);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SLOT;
                    cnt_d   = '0;
                end
            end
            ST_SLOT: begin
                if (accept) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(SLOT_LEN - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (req_acr) begin
                ptype_d = PKT_ACR;
                gacr_d  = 1'b1;
                run_d   = '0;
            end else if (req_audio && !force_if) begin
                ptype_d = PKT_AUDIO;
                gaud_d  = 1'b1;
                if (run_q != RW'(MAX_AUDIO_RUN)) run_d = run_q + 1'b1;
            end else if (arb_valid) begin
                ptype_d = gnt_type;
                gif_d   = arb_gnt;
                sent_d  = sent_eff | arb_gnt;
                ptr_d   = (gnt_idx == PW'(NUM_IF - 1)) ? '0 : gnt_idx + 1'b1;
                run_d   = '0;
            end else begin
                ptype_d = PKT_NULL;
                run_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptype_q <= PKT_NULL;
            gacr_q  <= 1'b0;
            gaud_q  <= 1'b0;
            gif_q   <= '0;
            sent_q  <= '0;
            ptr_q   <= '0;
            run_q   <= '0;
            field_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptype_q <= ptype_d;
            gacr_q  <= gacr_d;
            gaud_q  <= gaud_d;
            gif_q   <= gif_d;
            sent_q  <= sent_d;
            ptr_q   <= ptr_d;
            run_q   <= run_d;
            field_q <= field_d;
            miss_q  <= miss_d;
        end
    end

    assign packet_type = ptype_q;
    assign grant_acr   = gacr_q;
    assign grant_audio = gaud_q;
    assign grant_if    = gif_q;
    assign slot_busy   = (state_q == ST_SLOT);
    assign if_missed   = miss_q;

`ifdef PACKET_SCHED_STATS_EN
    logic [15:0] smiss_q, snull_q, sforce_q;
    logic        null_hit, force_hit;

    assign null_hit  = accept && !req_acr && !req_audio && !arb_valid;
    assign force_hit = accept && !req_acr && req_audio && force_if;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            smiss_q  <= '0;
            snull_q  <= '0;
            sforce_q <= '0;
        end else begin
            if (miss_d && smiss_q != 16'hFFFF)     smiss_q  <= smiss_q + 1'b1;
            if (null_hit && snull_q != 16'hFFFF)   snull_q  <= snull_q + 1'b1;
            if (force_hit && sforce_q != 16'hFFFF) sforce_q <= sforce_q + 1'b1;
        end
    end

    assign stat_missed = smiss_q;
    assign stat_null   = snull_q;
    assign stat_forced = sforce_q;
`endif

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed scoreboard bench for hdmi_packet_scheduler (default parameters).
// Expected decisions are queued at each accept and popped when the slot decision appears.
module tb_hdmi_packet_scheduler;
    import hdmi_packet_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] pt;
        logic [4:0] gnt;
    } exp_t;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b0;
    logic       video_field_end = 1'b0;
    logic       packet_enable   = 1'b0;
    logic       req_acr   = 1'b0;
    logic       req_audio = 1'b0;
    logic [2:0] if_enable = 3'b000;
    logic [7:0] packet_type;
    logic       grant_acr, grant_audio, slot_busy, if_missed;
    logic [2:0] grant_if;
`ifdef PACKET_SCHED_STATS_EN
    logic [15:0] stat_missed, stat_null, stat_forced;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    hdmi_packet_scheduler dut (
        .clk_pixel       (clk_pixel),
        .reset_n         (reset_n),
        .video_field_end (video_field_end),
        .packet_enable   (packet_enable),
        .req_acr         (req_acr),
        .req_audio       (req_audio),
        .if_enable       (if_enable),
        .packet_type     (packet_type),
        .grant_acr       (grant_acr),
        .grant_audio     (grant_audio),
        .grant_if        (grant_if),
        .slot_busy       (slot_busy),
        .if_missed       (if_missed)
`ifdef PACKET_SCHED_STATS_EN
       ,.stat_missed     (stat_missed),
        .stat_null       (stat_null),
        .stat_forced     (stat_forced)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        packet_enable   = 1'b0;
        video_field_end = 1'b0;
        req_acr         = 1'b0;
        req_audio       = 1'b0;
        tick(2);
        chk("rst type", {24'h0, packet_type}, 32'h00);
        chk("rst grants", {27'h0, grant_acr, grant_audio, grant_if}, 32'h0);
        chk("rst busy_missed", {30'h0, slot_busy, if_missed}, 32'h0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
    endtask

    task automatic accept_check(input string tag, input logic [7:0] pt, input logic [4:0] gnt);
        exp_t e;
        e.tag = tag;
        e.pt  = pt;
        e.gnt = gnt;
        sb.push_back(e);
        @(negedge clk_pixel);
        packet_enable = 1'b1;
        @(posedge clk_pixel);
        #1;
        packet_enable = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, " type"}, {24'h0, packet_type}, {24'h0, e.pt});
            chk({e.tag, " grants"}, {27'h0, grant_acr, grant_audio, grant_if}, {27'h0, e.gnt});
            chk({e.tag, " busy"}, {31'h0, slot_busy}, 32'h1);
        end
    endtask

    initial begin
        // 1: InfoFrames in round-robin order, then NULL
        if_enable = 3'b111;
        do_reset();
        accept_check("t1 s0", 8'h84, 5'b00_001);
        tick(1);
        chk("t1 pulse_drop", {27'h0, grant_acr, grant_audio, grant_if}, 32'h0);
        chk("t1 type_hold", {24'h0, packet_type}, 32'h84);
        tick(30);
        accept_check("t1 s1", 8'h82, 5'b00_010);
        tick(31);
        accept_check("t1 s2", 8'h83, 5'b00_100);
        tick(31);
        chk("t1 busy_end", {31'h0, slot_busy}, 32'h1);
        accept_check("t1 s3", 8'h00, 5'b00_000);
        tick(32);
        chk("t1 idle", {31'h0, slot_busy}, 32'h0);

        // 2: ACR beats audio, then audio
        do_reset();
        req_acr   = 1'b1;
        req_audio = 1'b1;
        accept_check("t2 acr", 8'h01, 5'b10_000);
        req_acr = 1'b0;
        tick(31);
        accept_check("t2 aud", 8'h02, 5'b01_000);

        // 3: anti-starvation forces IF 0 after four audio grants
        if_enable = 3'b001;
        do_reset();
        req_audio = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept_check($sformatf("t3 aud%0d", i), 8'h02, 5'b01_000);
            tick(31);
        end
        accept_check("t3 forced", 8'h84, 5'b00_001);
        tick(31);
        accept_check("t3 resume", 8'h02, 5'b01_000);

        // 4: field end mid-slot, missed InfoFrame, same-cycle clear
        tick(5);
        @(negedge clk_pixel);
        video_field_end = 1'b1;
        tick(1);
        video_field_end = 1'b0;
        chk("t4 no_miss", {31'h0, if_missed}, 32'h0);
        chk("t4 mid_type", {24'h0, packet_type}, 32'h02);
        chk("t4 mid_busy", {31'h0, slot_busy}, 32'h1);
        tick(25);
        accept_check("t4 aud", 8'h02, 5'b01_000);
        tick(3);
        @(negedge clk_pixel);
        video_field_end = 1'b1;
        tick(1);
        video_field_end = 1'b0;
        chk("t4 miss", {31'h0, if_missed}, 32'h1);
        tick(1);
        chk("t4 miss_pulse", {31'h0, if_missed}, 32'h0);
        req_audio = 1'b0;
        tick(26);
        accept_check("t4 if0", 8'h84, 5'b00_001);
        tick(31);
        video_field_end = 1'b1;
        accept_check("t4 fe_accept", 8'h84, 5'b00_001);
        video_field_end = 1'b0;
        chk("t4 fe_no_miss", {31'h0, if_missed}, 32'h0);

        // 5: mid-slot enable ignored, back-to-back at cnt 31
        if_enable = 3'b111;
        do_reset();
        accept_check("t5 s0", 8'h84, 5'b00_001);
        tick(10);
        @(negedge clk_pixel);
        packet_enable = 1'b1;
        tick(1);
        packet_enable = 1'b0;
        chk("t5 ign_type", {24'h0, packet_type}, 32'h84);
        chk("t5 ign_grants", {27'h0, grant_acr, grant_audio, grant_if}, 32'h0);
        chk("t5 ign_busy", {31'h0, slot_busy}, 32'h1);
        tick(20);
        chk("t5 busy31", {31'h0, slot_busy}, 32'h1);
        accept_check("t5 b2b", 8'h82, 5'b00_010);

        // 6: asynchronous reset mid-slot, then a normal decision
        do_reset();
        accept_check("t6 s0", 8'h84, 5'b00_001);
        tick(15);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 async_type", {24'h0, packet_type}, 32'h00);
        chk("t6 async_busy", {31'h0, slot_busy}, 32'h0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        accept_check("t6 after", 8'h84, 5'b00_001);
        tick(1);
        chk("t6 sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
